// File: rtl/alarm_responder.sv
// Alarm consumer: drives the buzzer pattern, handles stop/snooze,
// and hands stop_alarm pulses back to the alarm trigger.
module alarm_responder #(
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int SNOOZE_SEC       = 300,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       alarm_triggered,
    input  logic       alarm_active,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    output logic       stop_alarm,
    output logic       buzzer,
    output logic       ringing,
    output logic       snooze_active,
    output logic [1:0] snooze_count
);

    localparam int RW = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int SW = $clog2(SNOOZE_SEC + 1);

    localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_SEC - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SEC - 1);
    localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [RW-1:0] ring_cnt, ring_cnt_n;
    logic [SW-1:0] snz_cnt, snz_cnt_n;
    logic        phase, phase_n;
    logic [1:0]  scount_n;
    logic        stop_n;

    // The trigger's latch level is informational only here.
    logic unused_alarm_active;
    assign unused_alarm_active = alarm_active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ring_cnt      <= '0;
            snz_cnt       <= '0;
            phase         <= 1'b0;
            snooze_count  <= 2'd0;
            stop_alarm    <= 1'b0;
            buzzer        <= 1'b0;
            ringing       <= 1'b0;
            snooze_active <= 1'b0;
        end else begin
            state         <= state_n;
            ring_cnt      <= ring_cnt_n;
            snz_cnt       <= snz_cnt_n;
            phase         <= phase_n;
            snooze_count  <= scount_n;
            stop_alarm    <= stop_n;
            buzzer        <= (state_n == RING) & phase_n;
            ringing       <= (state_n == RING);
            snooze_active <= (state_n == SNOOZE);
        end
    end

    always_comb begin
        state_n    = state;
        ring_cnt_n = ring_cnt;
        snz_cnt_n  = snz_cnt;
        phase_n    = phase;
        scount_n   = snooze_count;
        stop_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (alarm_triggered) begin
                    state_n    = RING;
                    ring_cnt_n = '0;
                    phase_n    = 1'b1;
                    scount_n   = 2'd0;
                end
            end
            RING: begin
                if (btn_stop) begin
                    state_n = IDLE;
                    stop_n  = 1'b1;
                end else if (tick_1s && ring_cnt == RING_LAST) begin
                    state_n = IDLE;
                    stop_n  = 1'b1;
                end else if (btn_snooze && snooze_count < SNZ_MAX) begin
                    state_n   = SNOOZE;
                    stop_n    = 1'b1;
                    scount_n  = snooze_count + 2'd1;
                    snz_cnt_n = '0;
                end else if (tick_1s) begin
                    phase_n    = ~phase;
                    ring_cnt_n = ring_cnt + RW'(1);
                end
            end
            SNOOZE: begin
                // Trigger is already cleared, so no stop pulse here.
                if (btn_stop) begin
                    state_n  = IDLE;
                    scount_n = 2'd0;
                end else if (alarm_triggered) begin
                    state_n    = RING;
                    ring_cnt_n = '0;
                    phase_n    = 1'b1;
                    scount_n   = 2'd0;
                end else if (tick_1s) begin
                    if (snz_cnt == SNZ_LAST) begin
                        state_n    = RING;
                        ring_cnt_n = '0;
                        phase_n    = 1'b1;
                    end else begin
                        snz_cnt_n = snz_cnt + SW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alarm_responder.sv
// Bench for alarm_responder: directed scenarios plus random
// button/trigger traffic checked against a seconds-based model.
module tb_alarm_responder;

    localparam int RT = 6;
    localparam int SS = 4;
    localparam int MS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1s = 1'b0;
    logic       alarm_triggered = 1'b0;
    logic       alarm_active = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_snooze = 1'b0;
    logic       stop_alarm;
    logic       buzzer;
    logic       ringing;
    logic       snooze_active;
    logic [1:0] snooze_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Model: 0 idle, 1 ringing, 2 snoozing; secs = whole seconds in mode
    int m_mode = 0;
    int m_secs = 0;
    int m_used = 0;
    int m_stop = 0;

    always #5 clk = ~clk;

    alarm_responder #(
        .RING_TIMEOUT_SEC(RT),
        .SNOOZE_SEC(SS),
        .MAX_SNOOZE(MS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick_1s(tick_1s),
        .alarm_triggered(alarm_triggered),
        .alarm_active(alarm_active),
        .btn_stop(btn_stop),
        .btn_snooze(btn_snooze),
        .stop_alarm(stop_alarm),
        .buzzer(buzzer),
        .ringing(ringing),
        .snooze_active(snooze_active),
        .snooze_count(snooze_count)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_secs = 0;
        m_used = 0;
        m_stop = 0;
    endtask

    task automatic model(input bit trig, input bit tk, input bit st, input bit sz);
        m_stop = 0;
        if (m_mode == 0) begin
            if (trig) begin
                m_mode = 1; m_secs = 0; m_used = 0;
            end
        end else if (m_mode == 1) begin
            if (st) begin
                m_mode = 0; m_stop = 1;
            end else if (tk && m_secs + 1 == RT) begin
                m_mode = 0; m_stop = 1;
            end else if (sz && m_used < MS) begin
                m_mode = 2; m_secs = 0; m_used++; m_stop = 1;
            end else if (tk) begin
                m_secs++;
            end
        end else begin
            if (st) begin
                m_mode = 0; m_used = 0;
            end else if (trig) begin
                m_mode = 1; m_secs = 0; m_used = 0;
            end else if (tk) begin
                m_secs++;
                if (m_secs == SS) begin
                    m_mode = 1; m_secs = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("stop_alarm", int'(stop_alarm), m_stop);
        chk("ringing", int'(ringing), int'(m_mode == 1));
        chk("snooze_active", int'(snooze_active), int'(m_mode == 2));
        chk("buzzer", int'(buzzer), int'(m_mode == 1 && m_secs % 2 == 0));
        chk("snooze_count", int'(snooze_count), m_used);
    endtask

    task automatic step(input bit trig, input bit st, input bit sz);
        bit tk;
        tk = (cyc % 10 == 9);
        tick_1s = tk;
        alarm_triggered = trig;
        btn_stop = st;
        btn_snooze = sz;
        @(posedge clk);
        model(trig, tk, st, sz);
        cyc++;
        #1;
        tick_1s = 1'b0;
        alarm_triggered = 1'b0;
        btn_stop = 1'b0;
        btn_snooze = 1'b0;
        if (m_stop != 0) alarm_active = 1'b0;
        if (trig) alarm_active = 1'b1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_mode(input string tag, input int mode, input int secs);
        int k;
        k = 0;
        while (!(m_mode == mode && m_secs == secs) && k < 200) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        chk(tag, int'(k < 200), 1);
    endtask

    initial begin
        int pulses;
        int k;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_all();
        reset = 1'b1;
        idle(3);

        // 1: ring until timeout
        step(1'b1, 1'b0, 1'b0);
        chk("t1_ring", int'(ringing), 1);
        chk("t1_buzz", int'(buzzer), 1);
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            step(1'b0, 1'b0, 1'b0);
            pulses += int'(stop_alarm);
        end
        chk("t1_pulses", pulses, 1);
        chk("t1_idle", int'(ringing), 0);

        // 2: stop after two ticks
        step(1'b1, 1'b0, 1'b0);
        wait_mode("t2_wait", 1, 2);
        step(1'b0, 1'b1, 1'b0);
        chk("t2_stop", int'(stop_alarm), 1);
        chk("t2_ring", int'(ringing), 0);
        idle(3);

        // 3: snooze, re-ring, snooze limit
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("t3_snz", int'(snooze_active), 1);
        chk("t3_cnt1", int'(snooze_count), 1);
        wait_mode("t3_rering1", 1, 0);
        chk("t3_buzz", int'(buzzer), 1);
        step(1'b0, 1'b0, 1'b1);
        chk("t3_cnt2", int'(snooze_count), 2);
        wait_mode("t3_rering2", 1, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("t3_ignored_ring", int'(ringing), 1);
        chk("t3_ignored_stop", int'(stop_alarm), 0);
        step(1'b0, 1'b1, 1'b0);
        idle(3);

        // 4: stop coincident with timeout tick
        step(1'b1, 1'b0, 1'b0);
        k = 0;
        while (!(m_mode == 1 && m_secs == RT - 1 && cyc % 10 == 9) && k < 200) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        chk("t4_wait", int'(k < 200), 1);
        step(1'b0, 1'b1, 1'b0);
        pulses = int'(stop_alarm);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0);
            pulses += int'(stop_alarm);
        end
        chk("t4_pulses", pulses, 1);
        chk("t4_idle", int'(ringing), 0);

        // 5: new trigger in snooze, stop in snooze
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_ring", int'(ringing), 1);
        chk("t5_cnt", int'(snooze_count), 0);
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b0, 1'b1, 1'b0);
        chk("t5_nostop", int'(stop_alarm), 0);
        chk("t5_idle", int'(snooze_active), 0);
        idle(3);

        // 6: async reset mid-ring
        step(1'b1, 1'b0, 1'b0);
        chk("t6_buzz", int'(buzzer), 1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        #4;
        reset = 1'b1;
        idle(30);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
